// File: rtl/video_frame_buffer_pkg.sv
// Shared video definitions: frame geometry defaults and the frame-buffer control states.
package video_frame_buffer_pkg;

  localparam int unsigned FRAME_W      = 160;
  localparam int unsigned FRAME_H      = 144;
  localparam int unsigned FRAME_DEPTH  = FRAME_W * FRAME_H;
  localparam int unsigned FRAME_ADDR_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_PENDING = 2'd2
  } fb_state_e;

endpackage

// File: rtl/video_ram_dp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module video_ram_dp #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [WORDS];

  // Read-first: a same-address read returns the value held before this edge's write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_frame_buffer.sv
// Double-buffered pixel store: writer fills the back bank, scanout reads the front bank,
// banks swap at the first vsync after the writer reports a finished frame.
module video_frame_buffer
  import video_frame_buffer_pkg::*;
#(
  parameter int unsigned         PIXEL_W     = 2,
  parameter int unsigned         DEPTH       = FRAME_DEPTH,
  parameter int unsigned         ADDR_W      = FRAME_ADDR_W,
  parameter logic [PIXEL_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               wr_frame_done,
  input  logic               clear_req,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_frame_start,
  output logic               swap_pending,
  output logic               front_bank,
  output logic [7:0]         frame_count
);

  fb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                clr_last_c;
  logic                wr_in_range_c;
  logic                rd_in_range_c;
  logic                swap_c;
  logic                ram_we_c;
  logic [ADDR_W:0]     ram_waddr_c;
  logic [PIXEL_W-1:0]  ram_wdata_c;
  logic [ADDR_W:0]     ram_raddr_c;
  logic [PIXEL_W-1:0]  ram_q;
  logic                rd_zero_q;

  assign clr_last_c    = (clr_cnt_q == ADDR_W'(DEPTH - 1));
  assign wr_in_range_c = (32'(wr_addr) < DEPTH);
  assign rd_in_range_c = (32'(rd_addr) < DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req)                            state_d = ST_CLEAR;
        else if (wr_frame_done && !rd_frame_start) state_d = ST_PENDING;
      end
      ST_CLEAR:   if (clr_last_c)     state_d = ST_IDLE;
      ST_PENDING: if (rd_frame_start) state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Back-bank write port, clear sequencing and swap decode.
  always_comb begin
    swap_c      = 1'b0;
    ram_we_c    = 1'b0;
    ram_waddr_c = {~front_bank, wr_addr};
    ram_wdata_c = wr_data;
    clr_cnt_d   = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        ram_we_c = wr_en && !clear_req && wr_in_range_c;
        swap_c   = !clear_req && wr_frame_done && rd_frame_start;
      end
      ST_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_waddr_c = {~front_bank, clr_cnt_q};
        ram_wdata_c = CLEAR_VALUE;
        clr_cnt_d   = clr_last_c ? '0 : clr_cnt_q + ADDR_W'(1);
      end
      ST_PENDING: swap_c = rd_frame_start;
      default: ;
    endcase
  end

  // A read coinciding with a swap already targets the incoming front bank.
  assign ram_raddr_c = {front_bank ^ swap_c, rd_addr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_q    <= '0;
      front_bank   <= 1'b0;
      frame_count  <= 8'd0;
      swap_pending <= 1'b0;
      wr_ready     <= 1'b1;
      rd_valid     <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      clr_cnt_q    <= clr_cnt_d;
      swap_pending <= (state_d == ST_PENDING);
      wr_ready     <= (state_d == ST_IDLE);
      rd_valid     <= rd_en;
      if (rd_en) rd_zero_q <= !rd_in_range_c;
      if (swap_c) begin
        front_bank  <= ~front_bank;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign rd_data = rd_zero_q ? '0 : ram_q;

  video_ram_dp #(
    .DATA_W (PIXEL_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wdata (ram_wdata_c),
    .re    (rd_en),
    .raddr (ram_raddr_c),
    .rdata (ram_q)
  );

endmodule

// File: doc/video_frame_buffer.md
VIDEO_FRAME_BUFFER -- requirements
Module: video_frame_buffer

Interface
REQ-001 SHALL have parameter PIXEL_W, default 2, meaning bits per pixel.
REQ-002 SHALL have parameter DEPTH, default 23040 (160x144), meaning pixels per frame.
REQ-003 SHALL have parameter ADDR_W, default 15, meaning pixel address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter CLEAR_VALUE, default 0, meaning the PIXEL_W-bit fill value used by a clear.
REQ-005 SHALL have ports clk (in, 1, single clock) and reset_n (in, 1); one clock, reset asynchronous and active-low.
REQ-006 SHALL have wr_en (in, 1), wr_addr (in, ADDR_W) and wr_data (in, PIXEL_W): the back-buffer pixel write.
REQ-007 SHALL have wr_ready (out, 1): writes and clears are accepted.
REQ-008 SHALL have wr_frame_done (in, 1): a one-cycle pulse, back frame complete.
REQ-009 SHALL have clear_req (in, 1): a one-cycle pulse, fill the back buffer with CLEAR_VALUE.
REQ-010 SHALL have rd_en (in, 1) and rd_addr (in, ADDR_W): the front-buffer read request.
REQ-011 SHALL have rd_data (out, PIXEL_W) and rd_valid (out, 1): the read result.
REQ-012 SHALL have rd_frame_start (in, 1): a one-cycle pulse at the scanout frame start (vsync).
REQ-013 SHALL have swap_pending (out, 1), front_bank (out, 1) and frame_count (out, 8, swaps completed).

Function
REQ-014 SHALL hold two banks of DEPTH pixels; the reader accesses bank front_bank and the writer accesses bank ~front_bank.
REQ-015 SHALL operate a state machine with states IDLE, CLEAR and PENDING.
REQ-016 SHALL assert wr_ready only in IDLE.
REQ-017 SHALL, in IDLE, write wr_data to back[wr_addr] on the edge where wr_en=1, if wr_addr < DEPTH; an out-of-range wr_addr SHALL be ignored.
REQ-018 SHALL ignore wr_en whenever wr_ready=0; no write is queued.
REQ-019 SHALL, on clear_req in IDLE, enter CLEAR and write CLEAR_VALUE to back addresses 0..DEPTH-1, one per cycle, ascending.
REQ-020 SHALL return to IDLE on the cycle after the DEPTH-1 write, so CLEAR lasts exactly DEPTH cycles.
REQ-021 SHALL give clear_req priority over wr_en when both are asserted in the same IDLE cycle; that wr_en is discarded.
REQ-022 SHALL ignore clear_req in CLEAR and in PENDING.
REQ-023 SHALL ignore wr_frame_done while in CLEAR.
REQ-024 SHALL, on wr_frame_done in IDLE without rd_frame_start, enter PENDING and set swap_pending=1.
REQ-025 SHALL, on rd_frame_start in PENDING, toggle front_bank, increment frame_count (modulo 256), clear swap_pending and return to IDLE, all on that edge.
REQ-026 SHALL, when wr_frame_done and rd_frame_start coincide in IDLE, swap immediately on that edge and not enter PENDING.
REQ-027 SHALL have rd_frame_start cause no action in IDLE or CLEAR.
REQ-028 SHALL give read latency of exactly 1 cycle: rd_valid and rd_data follow rd_en by one clock.
REQ-029 SHALL return rd_data = 0 when rd_addr >= DEPTH, with rd_valid still asserted.
REQ-030 SHALL read from the bank that is front after the edge when rd_en and a swapping rd_frame_start coincide, i.e. the new frame.
REQ-031 SHALL hold rd_data at its last value when rd_en=0 and deassert rd_valid.
REQ-032 SHALL leave the read port fully independent of the write/clear state; reads are never stalled.

Reset
REQ-033 SHALL, on reset_n=0, asynchronously force: state IDLE, front_bank 0, swap_pending 0, frame_count 0, rd_valid 0, rd_data 0, clear counter 0.
REQ-034 SHALL not initialise memory contents on reset.
REQ-035 SHALL abort a clear or pending swap in progress at reset, with no swap occurring.
REQ-036 SHALL accept writes on the first clk edge after reset_n deasserts.

Structure
REQ-037 SHALL place the state enum (IDLE/CLEAR/PENDING) and the default frame constants (160, 144, DEPTH, ADDR_W) in the shared video package.
REQ-038 SHALL instantiate one sub-module, video_ram_dp: a simple dual-port synchronous RAM with 1-cycle read, addressed by {bank, addr}, (ADDR_W+1) wide.
REQ-039 SHALL keep all control logic in video_frame_buffer; video_ram_dp contains no control logic.

Verification
REQ-040 SHALL verify write and swap: write 3 to addr 5, pulse wr_frame_done, pulse rd_frame_start, read addr 5 -> rd_data=3 one cycle later, front_bank=1, frame_count=1.
REQ-041 SHALL verify the pending stall: wr_frame_done with no vsync -> swap_pending=1, wr_ready=0; a wr_en to addr 5 with data 1 is dropped; after rd_frame_start -> wr_ready=1.
REQ-042 SHALL verify coincidence: wr_frame_done and rd_frame_start on the same cycle -> front_bank toggles that edge, swap_pending never 1, and a read issued that cycle returns the new front data.
REQ-043 SHALL verify clear: clear_req with CLEAR_VALUE=2 and DEPTH=16 -> wr_ready low exactly 16 cycles; after a swap, reads of addrs 0..15 all return 2.
REQ-044 SHALL verify bounds: wr_addr=DEPTH is ignored; rd_addr=DEPTH -> rd_data=0, rd_valid=1.
REQ-045 SHALL verify reset mid-operation: reset_n low during CLEAR at count 7 -> state IDLE, front_bank 0, frame_count 0, rd_valid 0.
